// File: rtl/time_set_ctrl_pkg.sv
// Shared types and helpers for the hh:mm:ss time-set controller.
// State encoding doubles as the field code reported to the display mux.
package time_set_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SET_HH = 2'd1,
    ST_SET_MM = 2'd2,
    ST_SET_SS = 2'd3
  } state_t;

  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_HH   = 2'd1;
  localparam logic [1:0] FLD_MM   = 2'd2;
  localparam logic [1:0] FLD_SS   = 2'd3;

  localparam logic [7:0] HH_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

  // Out-of-range or non-BCD values snap to 00 so a bad capture self-heals on first inc.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] r;
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v >= max_v) r = 8'h00;
    else if (v[3:0] == 4'd9)                          r = {v[7:4] + 4'd1, 4'h0};
    else                                              r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-level filter, one-cycle press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int unsigned   CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic          r_pulse;
  logic [CW-1:0] r_cnt;

  // Level flips only after DEBOUNCE_CYCLES consecutive samples that disagree with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_pulse   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_pulse   <= r_level & ~r_level_d;
      if (r_sync2 == r_level) begin
        r_cnt <= RELOAD;
      end else if (r_cnt == '0) begin
        r_level <= r_sync2;
        r_cnt   <= RELOAD;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/time_set_ctrl.sv
// Edit FSM, BCD field increment and blink timer for setting the hh:mm:ss clock.
//   state     | meaning
//   ST_RUN    | clock runs, inc ignored
//   ST_SET_HH | editing hours
//   ST_SET_MM | editing minutes
//   ST_SET_SS | editing seconds, next mode loads the counter
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned BLINK_CYCLES    = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic [23:0] cur_time,
  output logic [23:0] set_time,
  output logic        load,
  output logic        setting,
  output logic [1:0]  field,
  output logic        blink
);

  localparam int unsigned   BW           = $clog2(BLINK_CYCLES + 1);
  localparam logic [BW-1:0] BLINK_RELOAD = BW'(BLINK_CYCLES - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [23:0]   r_set_time;
  logic [23:0]   w_set_time_nxt;
  logic          r_load;
  logic          w_load_nxt;
  logic          r_setting;
  logic [1:0]    r_field;
  logic [1:0]    w_field_nxt;
  logic          r_blink;
  logic          w_blink_restart;
  logic [BW-1:0] r_blink_cnt;
  logic          w_mode_p;
  logic          w_inc_p;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_mode),
    .o_pulse (w_mode_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_inc),
    .o_pulse (w_inc_p)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_set_time  <= '0;
      r_load      <= 1'b0;
      r_setting   <= 1'b0;
      r_field     <= FLD_NONE;
      r_blink     <= 1'b0;
      r_blink_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_set_time <= w_set_time_nxt;
      r_load     <= w_load_nxt;
      // Lags state by one cycle so setting is still high alongside the load strobe.
      r_setting  <= (r_state != ST_RUN);
      r_field    <= w_field_nxt;
      if (w_blink_restart) begin
        r_blink     <= 1'b0;
        r_blink_cnt <= BLINK_RELOAD;
      end else if (r_blink_cnt == '0) begin
        r_blink     <= ~r_blink;
        r_blink_cnt <= BLINK_RELOAD;
      end else begin
        r_blink_cnt <= r_blink_cnt - BW'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_mode_p) begin
      case (r_state)
        ST_RUN:    w_state_nxt = ST_SET_HH;
        ST_SET_HH: w_state_nxt = ST_SET_MM;
        ST_SET_MM: w_state_nxt = ST_SET_SS;
        ST_SET_SS: w_state_nxt = ST_RUN;
        default:   w_state_nxt = ST_RUN;
      endcase
    end
  end

  // Mode has priority: an inc landing in the same cycle as mode is dropped.
  always_comb begin
    w_set_time_nxt  = r_set_time;
    w_load_nxt      = 1'b0;
    w_field_nxt     = FLD_NONE;
    w_blink_restart = w_mode_p | w_inc_p | (w_state_nxt == ST_RUN);
    case (w_state_nxt)
      ST_SET_HH: w_field_nxt = FLD_HH;
      ST_SET_MM: w_field_nxt = FLD_MM;
      ST_SET_SS: w_field_nxt = FLD_SS;
      default:   w_field_nxt = FLD_NONE;
    endcase
    if (w_mode_p) begin
      if (r_state == ST_RUN) w_set_time_nxt = cur_time;
      w_load_nxt = (r_state == ST_SET_SS);
    end else if (w_inc_p) begin
      case (r_state)
        ST_SET_HH: w_set_time_nxt[23:16] = bcd_inc(r_set_time[23:16], HH_MAX);
        ST_SET_MM: w_set_time_nxt[15:8]  = bcd_inc(r_set_time[15:8],  MS_MAX);
        ST_SET_SS: w_set_time_nxt[7:0]   = bcd_inc(r_set_time[7:0],   MS_MAX);
        default:   w_set_time_nxt        = r_set_time;
      endcase
    end
  end

  assign set_time = r_set_time;
  assign load     = r_load;
  assign setting  = r_setting;
  assign field    = r_field;
  assign blink    = r_blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed edit scenarios plus random button/time stimulus
// checked every cycle against a cycle-level behavioural model of the controller.
module tb_time_set_ctrl;

  localparam int DEB = 4;
  localparam int BLK = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic [23:0] cur_time = '0;
  logic [23:0] set_time;
  logic        load;
  logic        setting;
  logic [1:0]  field;
  logic        blink;

  int n_checks = 0;
  int n_fail   = 0;

  time_set_ctrl #(.DEBOUNCE_CYCLES(DEB), .BLINK_CYCLES(BLK)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .cur_time (cur_time),
    .set_time (set_time),
    .load     (load),
    .setting  (setting),
    .field    (field),
    .blink    (blink)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [DEB+1:0] m_hist [2];   // raw samples, bit 0 newest
  logic [1:0]     m_lvl, m_rose1, m_rose2;
  int             m_field, m_bcnt, m_load_cnt;
  logic [23:0]    m_set, m_last_load;
  logic           m_load, m_setting, m_blink;
  int             d_load_cnt = 0;
  logic [23:0]    d_last_load = '0;

  function automatic logic [7:0] bcd_step(input logic [7:0] v, input int maxd);
    int hi, lo, d;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9 || lo > 9 || hi * 10 + lo > maxd) d = 0;
    else d = (hi * 10 + lo + 1) % (maxd + 1);
    return {4'(d / 10), 4'(d % 10)};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_hist[0] = '0; m_hist[1] = '0;
      m_lvl = '0; m_rose1 = '0; m_rose2 = '0;
      m_field = 0; m_bcnt = 0; m_set = '0;
      m_load = 0; m_setting = 0; m_blink = 0;
    end else begin
      logic mp, ip;
      logic [1:0] raw;
      raw = {btn_inc, btn_mode};
      mp = m_rose2[0];
      ip = m_rose2[1];
      for (int b = 0; b < 2; b++) begin
        m_rose2[b] = m_rose1[b];
        m_hist[b]  = {m_hist[b][DEB:0], raw[b]};
        m_rose1[b] = 1'b0;
        // synchronised level seen now is the raw sample from two edges ago
        if (m_hist[b][DEB+1:2] == {DEB{~m_lvl[b]}}) begin
          m_lvl[b]   = ~m_lvl[b];
          m_rose1[b] = m_lvl[b];
        end
      end
      m_setting = (m_field != 0);
      m_load = 0;
      if (mp) begin
        if (m_field == 0) m_set = cur_time;
        if (m_field == 3) begin
          m_load = 1;
          m_load_cnt++;
          m_last_load = m_set;
        end
        m_field = (m_field + 1) % 4;
      end else if (ip) begin
        case (m_field)
          1: m_set[23:16] = bcd_step(m_set[23:16], 23);
          2: m_set[15:8]  = bcd_step(m_set[15:8], 59);
          3: m_set[7:0]   = bcd_step(m_set[7:0], 59);
          default: ;
        endcase
      end
      if (mp || ip || m_field == 0) begin
        m_bcnt = 0;
        m_blink = 0;
      end else begin
        m_bcnt++;
        if (m_bcnt == BLK) begin
          m_bcnt = 0;
          m_blink = ~m_blink;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("set_time", set_time, m_set);
    chk("load", {23'd0, load}, {23'd0, m_load});
    chk("setting", {23'd0, setting}, {23'd0, m_setting});
    chk("field", {22'd0, field}, 24'(m_field));
    chk("blink", {23'd0, blink}, {23'd0, m_blink});
    if (load) begin
      d_load_cnt++;
      d_last_load = set_time;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    cycles(DEB + 4);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cycles(DEB + 6);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    cycles(2);
    rst = 1'b1;
    cycles(2);
  endtask

  function automatic logic [23:0] rand_bcd();
    return {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lc, tog;
    logic prev;
    m_load_cnt = 0;
    m_last_load = '0;
    cycles(3);
    chk("rst_set_time", set_time, 24'h0);
    chk("rst_outs", {19'd0, load, setting, field, blink}, 24'h0);
    rst = 1'b1;
    cycles(2);

    // bounce filtered, single inc in hours
    do_reset();
    cur_time = 24'h120000;
    press(1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      btn_inc = ~btn_inc;
      cycles(2);
    end
    btn_inc = 1'b1;
    cycles(10);
    btn_inc = 1'b0;
    cycles(10);
    chk("t1_hh", {16'd0, set_time[23:16]}, 24'h13);
    chk("t1_model_hh", {16'd0, m_set[23:16]}, 24'h13);

    // full edit with wraps, blink period, single load
    do_reset();
    cur_time = 24'h095930;
    press(1'b1, 1'b0);
    chk("t2_field_hh", {22'd0, field}, 24'd1);
    chk("t2_setting", {23'd0, setting}, 24'd1);
    tog = 0;
    prev = blink;
    repeat (32) begin
      @(negedge clk);
      if (blink != prev) tog++;
      prev = blink;
    end
    chk("t6_blink_toggles", 24'(tog), 24'd4);
    repeat (15) press(1'b0, 1'b1);
    chk("t2_hh_wrap", {16'd0, set_time[23:16]}, 24'h00);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("t2_mm_wrap", set_time, 24'h000030);
    press(1'b1, 1'b0);
    lc = d_load_cnt;
    press(1'b1, 1'b0);
    chk("t2_load_count", 24'(d_load_cnt - lc), 24'd1);
    chk("t2_load_value", d_last_load, 24'h000030);
    chk("t2_model_load", m_last_load, 24'h000030);
    chk("t6_after_load", {21'd0, setting, blink, load}, 24'h0);

    // seconds and hours wrap without carry
    do_reset();
    cur_time = 24'h235959;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("t3_hh", {16'd0, set_time[23:16]}, 24'h00);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("t3_ss", set_time, 24'h005900);
    press(1'b1, 1'b0);

    // mode and inc together: mode wins
    do_reset();
    cur_time = 24'h101010;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    chk("t4_field_mm", {22'd0, field}, 24'd2);
    press(1'b1, 1'b1);
    chk("t4_field_ss", {22'd0, field}, 24'd3);
    chk("t4_minutes", set_time, 24'h101010);

    // non-BCD capture snaps to 00 on first inc
    do_reset();
    cur_time = 24'h3A7F5C;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("nbcd_all", set_time, 24'h000000);

    // async reset mid-edit
    do_reset();
    cur_time = 24'h111111;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    lc = d_load_cnt;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t5_set_time", set_time, 24'h0);
    chk("t5_outs", {19'd0, load, setting, field, blink}, 24'h0);
    cycles(3);
    chk("t5_no_load", 24'(d_load_cnt - lc), 24'd0);
    rst = 1'b1;
    cycles(2);

    // random buttons, times and occasional resets
    for (int it = 0; it < 300; it++) begin
      cur_time = ($urandom_range(0, 3) == 0) ? 24'($urandom) : rand_bcd();
      case ($urandom_range(0, 5))
        0, 1: press(1'b1, 1'b0);
        2, 3: press(1'b0, 1'b1);
        4: press(1'b1, 1'b1);
        default: begin
          repeat ($urandom_range(1, 12)) begin
            btn_mode = 1'($urandom);
            btn_inc  = 1'($urandom);
            cycles($urandom_range(1, 6));
          end
          btn_mode = 1'b0;
          btn_inc  = 1'b0;
        end
      endcase
      if ($urandom_range(0, 39) == 0) begin
        @(posedge clk);
        #($urandom_range(1, 4)) rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end
    cycles(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
